// File: rtl/rf_sequencer_if.sv
// rtl/rf_sequencer_if.sv - instruction-memory and register-file/ALU control bundle
//
// Purpose: groups the fetch handshake and the datapath control signals driven
// by rf_sequencer. The master side is the sequencer; the slave side is the
// memory/datapath.
// Signals:
//   imem_req/imem_addr        fetch request and address (master -> slave)
//   imem_valid/imem_data      fetch response (slave -> master)
//   rf_read_reg1/2            register file read addresses
//   rf_read_data1             read data 1, used for branch decisions
//   rf_write_reg/reg_write    write address and one-cycle write enable
//   alu_op/wb_sel/imm         ALU op, write-back source select, immediate
interface rf_sequencer_if #(
   parameter int PC_W = 4
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid;
   logic [11:0]     imem_data;
   logic [1:0]      rf_read_reg1;
   logic [1:0]      rf_read_reg2;
   logic [3:0]      rf_read_data1;
   logic [1:0]      rf_write_reg;
   logic            reg_write;
   logic [1:0]      alu_op;
   logic            wb_sel;
   logic [3:0]      imm;

   modport master (
      output imem_req, imem_addr,
      input  imem_valid, imem_data,
      output rf_read_reg1, rf_read_reg2,
      input  rf_read_data1,
      output rf_write_reg, reg_write, alu_op, wb_sel, imm
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_valid, imem_data,
      input  rf_read_reg1, rf_read_reg2,
      output rf_read_data1,
      input  rf_write_reg, reg_write, alu_op, wb_sel, imm
   );
endinterface

// File: rtl/rf_sequencer.sv
// rtl/rf_sequencer.sv - multi-cycle fetch/decode/execute control FSM for the mini CPU
//
// Purpose: fetches 12-bit instructions, decodes them and drives the register
// file / ALU controls. Owns the PC and a saturating retired-instruction count.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   start         begin execution at PC 0 (honoured in IDLE and HALTED only)
//   bus           rf_sequencer_if master: fetch port and datapath controls
//   busy          high in FETCH/DECODE/EXEC/WB
//   halted        high in HALTED
//   illegal       one-cycle pulse in EXEC for opcodes 9..E
//   retired       completed instructions since last start, saturating
module rf_sequencer #(
   parameter int PC_W  = 4,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   rf_sequencer_if.master      bus,
   output logic                busy,
   output logic                halted,
   output logic                illegal,
   output logic [CNT_W-1:0]    retired
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
   } state_t;

   localparam logic [3:0] OP_LDI  = 4'h5;
   localparam logic [3:0] OP_MOV  = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_BEQZ = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [11:0]       ir_q, ir_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   logic [3:0]        opcode;
   logic [3:0]        opcode_m1;
   logic              is_alu;
   logic              is_wb_op;
   logic              is_illegal;
   logic [PC_W-1:0]   imm_pc;
   logic [CNT_W-1:0]  retired_inc;

   assign opcode     = ir_q[11:8];
   assign opcode_m1  = opcode - 4'd1;
   assign is_alu     = (opcode >= 4'h1) && (opcode <= 4'h4);
   assign is_wb_op   = is_alu || (opcode == OP_LDI) || (opcode == OP_MOV);
   assign is_illegal = (opcode >= 4'h9) && (opcode <= 4'hE);
   assign imm_pc     = PC_W'(ir_q[3:0]);
   // Counter holds at all-ones instead of wrapping.
   assign retired_inc = (retired_q == '1) ? retired_q : retired_q + CNT_ONE;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d   = S_FETCH;
               pc_d      = '0;
               retired_d = '0;
            end
         end
         S_FETCH: begin
            if (bus.imem_valid) begin
               ir_d    = bus.imem_data;
               pc_d    = pc_q + PC_ONE;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (is_wb_op) begin
               // Retirement for write-back ops is counted on leaving WB.
               state_d = S_WB;
            end else begin
               retired_d = retired_inc;
               state_d   = (opcode == OP_HALT) ? S_HALTED : S_FETCH;
               if (opcode == OP_JMP)
                  pc_d = imm_pc;
               if ((opcode == OP_BEQZ) && (bus.rf_read_data1 == 4'h0))
                  pc_d = imm_pc;
            end
         end
         S_WB: begin
            retired_d = retired_inc;
            state_d   = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: datapath controls decode straight from IR; strobes from state.
   always_comb begin
      bus.imem_req     = (state_q == S_FETCH);
      bus.imem_addr    = pc_q;
      bus.rf_read_reg1 = ir_q[5:4];
      bus.rf_read_reg2 = ir_q[3:2];
      bus.rf_write_reg = ir_q[7:6];
      bus.imm          = ir_q[3:0];
      bus.alu_op       = is_alu ? opcode_m1[1:0] : 2'b00;
      bus.wb_sel       = (opcode == OP_LDI) || (opcode == OP_MOV);
      bus.reg_write    = (state_q == S_WB);
      busy             = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXEC)  || (state_q == S_WB);
      halted           = (state_q == S_HALTED);
      illegal          = (state_q == S_EXEC) && is_illegal;
      retired          = retired_q;
   end

endmodule
